// File: rtl/alu_ctrl_ext_unit_pkg.sv
// alu_ctrl_ext_unit_pkg: shared FSM states, opcodes, mux encodings and ALU operation codes.
package alu_ctrl_ext_unit_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_READ = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
  localparam logic ADR_PC = 1'b0, ADR_RES = 1'b1;
  localparam logic [9:0] ALU_ADD  = 10'b0000000_000;
  localparam logic [9:0] ALU_SUB  = 10'b0100000_000;
  localparam logic [9:0] ALU_SLL  = 10'b0000000_001;
  localparam logic [9:0] ALU_SLT  = 10'b0000000_010;
  localparam logic [9:0] ALU_SLTU = 10'b0000000_011;
  localparam logic [9:0] ALU_XOR  = 10'b0000000_100;
  localparam logic [9:0] ALU_SRL  = 10'b0000000_101;
  localparam logic [9:0] ALU_SRA  = 10'b0100000_101;
  localparam logic [9:0] ALU_OR   = 10'b0000000_110;
  localparam logic [9:0] ALU_AND  = 10'b0000000_111;
endpackage

// File: rtl/alu_ctrl_ext_unit_if.sv
// alu_ctrl_ext_unit_if: instruction fields, operands and datapath controls of the multicycle control unit.
interface alu_ctrl_ext_unit_if;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [24:0] immValue;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        IRWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [9:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [31:0] immExt;
  modport master (
    output opcode, func3, func7, immValue, srcA, srcB,
    input  IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ALUResult, Zero, immExt
  );
  modport slave (
    input  opcode, func3, func7, immValue, srcA, srcB,
    output IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ALUResult, Zero, immExt
  );
endinterface

// File: rtl/alu_ctrl_ext_unit_alu_core.sv
// alu_core: combinational RV32I ALU keyed by the 10-bit {func7,func3} operation code.
module alu_core
  import alu_ctrl_ext_unit_pkg::*;
(
  input  logic [9:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);
  logic [4:0] sh;
  assign sh = b[4:0];
  always_comb begin
    case (ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $unsigned($signed(a) >>> sh);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end
  assign zero = y == '0;
endmodule

// File: rtl/alu_ctrl_ext_unit.sv
// alu_ctrl_ext_unit: RV32I multicycle control FSM, immediate extender and ALU.
// Define BRANCH_EXT_EN to add bne (func3=001) to the BRANCH state.
module alu_ctrl_ext_unit
  import alu_ctrl_ext_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  alu_ctrl_ext_unit_if.slave bus
);
  state_t      state;
  logic        br_take;
  logic [1:0]  imm_src;
  logic [24:0] iv;
  logic [31:0] alu_y;
  logic        alu_z;
  assign iv = bus.immValue;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else
      case (state)
        S_FETCH:   state <= S_DECODE;
        S_DECODE:  state <= (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                            bus.opcode == OP_R   ? S_EXECR  :
                            bus.opcode == OP_I   ? S_EXECI  :
                            bus.opcode == OP_B   ? S_BRANCH :
                            bus.opcode == OP_JAL ? S_JAL    : S_FETCH;
        S_MEMADR:  state <= bus.opcode == OP_LW ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: state <= S_MEMWB;
        S_EXECR, S_EXECI, S_JAL: state <= S_ALUWB;
        default:   state <= S_FETCH;
      endcase
  end
  // IRWrite is the only enable FETCH drives here; PCWrite is gated separately below
  always_comb begin
    bus.IRWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.AdrSrc     = ADR_PC;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        bus.IRWrite   = ~reset;
        bus.ALUSrcB   = SRCB_4;
        bus.ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: bus.AdrSrc = ADR_RES;
      S_MEMWB: begin
        bus.ResultSrc = RES_READ;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = ADR_RES;
        bus.MemWrite = 1'b1;
      end
      S_EXECR: begin
        bus.ALUSrcA    = SRCA_RD1;
        bus.ALUControl = {bus.func7, bus.func3};
      end
      S_EXECI: begin
        bus.ALUSrcA    = SRCA_RD1;
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = {bus.func3 == 3'b101 ? bus.func7 : 7'b0, bus.func3};
      end
      S_ALUWB: bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA    = SRCA_RD1;
        bus.ALUControl = ALU_SUB;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_4;
      end
      default: ;
    endcase
  end
`ifdef BRANCH_EXT_EN
  assign br_take = (bus.func3 == 3'b000 && alu_z) || (bus.func3 == 3'b001 && !alu_z);
`else
  assign br_take = bus.func3 == 3'b000 && alu_z;
`endif
  assign bus.PCWrite = ~reset & (state == S_FETCH || state == S_JAL || (state == S_BRANCH && br_take));
  assign imm_src = bus.opcode == OP_SW  ? IMM_S :
                   bus.opcode == OP_B   ? IMM_B :
                   bus.opcode == OP_JAL ? IMM_J : IMM_I;
  assign bus.ImmSrc = imm_src;
  assign bus.immExt = imm_src == IMM_S ? {{20{iv[24]}}, iv[24:18], iv[4:0]} :
                      imm_src == IMM_B ? {{20{iv[24]}}, iv[0], iv[23:18], iv[4:1], 1'b0} :
                      imm_src == IMM_J ? {{12{iv[24]}}, iv[12:5], iv[13], iv[23:14], 1'b0} :
                                         {{20{iv[24]}}, iv[24:13]};
  alu_core u_alu (
    .ctrl (bus.ALUControl),
    .a    (bus.srcA),
    .b    (bus.srcB),
    .y    (alu_y),
    .zero (alu_z)
  );
  assign bus.ALUResult = alu_y;
  assign bus.Zero      = alu_z;
endmodule

// File: tb/tb_alu_ctrl_ext_unit.sv
// tb_alu_ctrl_ext_unit: directed self-checking bench for the multicycle control unit.
module tb_alu_ctrl_ext_unit;
  import alu_ctrl_ext_unit_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  alu_ctrl_ext_unit_if bus ();
  alu_ctrl_ext_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // {IRWrite,MemWrite,AdrSrc,PCWrite,RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
  localparam logic [20:0] SIG_FETCH  = {5'b10010, 2'b00, 2'b10, 2'b10, 10'h000};
  localparam logic [20:0] SIG_RST    = {5'b00000, 2'b00, 2'b10, 2'b10, 10'h000};
  localparam logic [20:0] SIG_DECODE = {5'b00000, 2'b01, 2'b01, 2'b00, 10'h000};
  localparam logic [20:0] SIG_MEMADR = {5'b00000, 2'b10, 2'b01, 2'b00, 10'h000};
  localparam logic [20:0] SIG_MEMRD  = {5'b00100, 2'b00, 2'b00, 2'b00, 10'h000};
  localparam logic [20:0] SIG_MEMWB  = {5'b00001, 2'b00, 2'b00, 2'b01, 10'h000};
  localparam logic [20:0] SIG_MEMWR  = {5'b01100, 2'b00, 2'b00, 2'b00, 10'h000};
  localparam logic [20:0] SIG_ALUWB  = {5'b00001, 2'b00, 2'b00, 2'b00, 10'h000};
  localparam logic [20:0] SIG_JAL    = {5'b00010, 2'b01, 2'b10, 2'b00, 10'h000};
  typedef struct packed {
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;
  function automatic logic [20:0] sig();
    return {bus.IRWrite, bus.MemWrite, bus.AdrSrc, bus.PCWrite, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl};
  endfunction
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    nxt();
    checks++;
    if (sig() !== SIG_RST) begin errs++; $display("FAIL reset_state: got %h want %h", sig(), SIG_RST); end
  endtask
  task automatic test_extend();
    logic [6:0]  op [5];
    logic [24:0] iv [5];
    logic [1:0]  src [5];
    logic [31:0] ext [5];
    op  = '{OP_I, OP_I, OP_SW, OP_B, OP_R};
    iv  = '{25'h1FFE000, 25'h000A000, 25'h1FC001C, 25'h0000011, 25'h1FFE000};
    src = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    ext = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFC, 32'h00000810, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      bus.opcode = op[i];
      bus.immValue = iv[i];
      #2;
      checks++;
      if (bus.ImmSrc !== src[i]) begin errs++; $display("FAIL ext_immsrc[%0d]: got %b want %b", i, bus.ImmSrc, src[i]); end
      checks++;
      if (bus.immExt !== ext[i]) begin errs++; $display("FAIL ext_value[%0d]: got %h want %h", i, bus.immExt, ext[i]); end
    end
  endtask
  task automatic test_release();
    bus.srcA = 32'd0;
    bus.srcB = 32'd4;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (sig() !== SIG_FETCH) begin errs++; $display("FAIL release_fetch: got %h want %h", sig(), SIG_FETCH); end
    checks++;
    if (bus.ALUResult !== 32'd4) begin errs++; $display("FAIL release_pc4: got %h want %h", bus.ALUResult, 32'd4); end
  endtask
  task automatic test_lw();
    logic [20:0] exp [5];
    exp = '{SIG_FETCH, SIG_DECODE, SIG_MEMADR, SIG_MEMRD, SIG_MEMWB};
    bus.opcode = OP_LW;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sig() !== exp[i]) begin errs++; $display("FAIL lw_cycle%0d: got %h want %h", i + 1, sig(), exp[i]); end
      if (i < 4) nxt();
    end
    checks++;
    if (bus.ImmSrc !== 2'b00) begin errs++; $display("FAIL lw_immsrc: got %b want 00", bus.ImmSrc); end
    nxt();
    checks++;
    if (sig() !== SIG_FETCH) begin errs++; $display("FAIL lw_back_to_fetch: got %h want %h", sig(), SIG_FETCH); end
  endtask
  task automatic test_alu_ops();
    vec_t v [11];
    logic [20:0] exp;
    v = '{
      '{7'h00, 3'd0, 32'd5,        32'd7,        32'd12},
      '{7'h20, 3'd0, 32'd5,        32'd7,        32'hFFFFFFFE},
      '{7'h00, 3'd1, 32'd1,        32'h23,       32'd8},
      '{7'h00, 3'd2, 32'hFFFFFFFF, 32'd1,        32'd1},
      '{7'h00, 3'd3, 32'hFFFFFFFF, 32'd1,        32'd0},
      '{7'h00, 3'd4, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0},
      '{7'h00, 3'd5, 32'h80000000, 32'd4,        32'h08000000},
      '{7'h20, 3'd5, 32'h80000000, 32'd4,        32'hF8000000},
      '{7'h00, 3'd6, 32'h000000F0, 32'h0000000F, 32'h000000FF},
      '{7'h00, 3'd7, 32'h000000F0, 32'h0000003C, 32'h00000030},
      '{7'h01, 3'd0, 32'd5,        32'd7,        32'd0}
    };
    for (int i = 0; i < 11; i++) begin
      bus.opcode = OP_R;
      bus.func7 = v[i].f7;
      bus.func3 = v[i].f3;
      bus.srcA = v[i].a;
      bus.srcB = v[i].b;
      nxt();
      nxt();
      exp = {5'b00000, 2'b10, 2'b00, 2'b00, v[i].f7, v[i].f3};
      checks++;
      if (sig() !== exp) begin errs++; $display("FAIL execr_ctrl[%0d]: got %h want %h", i, sig(), exp); end
      checks++;
      if (bus.ALUResult !== v[i].y) begin errs++; $display("FAIL alu_result[%0d]: got %h want %h", i, bus.ALUResult, v[i].y); end
      checks++;
      if (bus.Zero !== (v[i].y == 32'd0)) begin errs++; $display("FAIL alu_zero[%0d]: got %b want %b", i, bus.Zero, v[i].y == 32'd0); end
      nxt();
      checks++;
      if (sig() !== SIG_ALUWB) begin errs++; $display("FAIL execr_aluwb[%0d]: got %h want %h", i, sig(), SIG_ALUWB); end
      nxt();
    end
  endtask
  task automatic test_execi();
    logic [6:0] f7 [3];
    logic [2:0] f3 [3];
    logic [9:0] ctl [3];
    logic [20:0] exp;
    f7  = '{7'h20, 7'h20, 7'h00};
    f3  = '{3'd5, 3'd0, 3'd5};
    ctl = '{10'b0100000_101, 10'b0000000_000, 10'b0000000_101};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = OP_I;
      bus.func7 = f7[i];
      bus.func3 = f3[i];
      nxt();
      nxt();
      exp = {5'b00000, 2'b10, 2'b01, 2'b00, ctl[i]};
      checks++;
      if (sig() !== exp) begin errs++; $display("FAIL execi[%0d]: got %h want %h", i, sig(), exp); end
      nxt();
      checks++;
      if (sig() !== SIG_ALUWB) begin errs++; $display("FAIL execi_aluwb[%0d]: got %h want %h", i, sig(), SIG_ALUWB); end
      nxt();
    end
  endtask
  task automatic test_branch();
    logic [2:0]  f3 [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic        pc [4];
    logic [20:0] exp;
    f3 = '{3'd0, 3'd0, 3'd1, 3'd1};
    a  = '{32'd9, 32'd9, 32'd9, 32'd9};
    b  = '{32'd9, 32'd8, 32'd8, 32'd9};
`ifdef BRANCH_EXT_EN
    pc = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    pc = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      bus.opcode = OP_B;
      bus.func7 = 7'h00;
      bus.func3 = f3[i];
      bus.srcA = a[i];
      bus.srcB = b[i];
      nxt();
      checks++;
      if (bus.ImmSrc !== 2'b10) begin errs++; $display("FAIL br_immsrc[%0d]: got %b want 10", i, bus.ImmSrc); end
      nxt();
      exp = {3'b000, pc[i], 1'b0, 2'b10, 2'b00, 2'b00, 10'b0100000_000};
      checks++;
      if (sig() !== exp) begin errs++; $display("FAIL branch[%0d]: got %h want %h", i, sig(), exp); end
      nxt();
      checks++;
      if (sig() !== SIG_FETCH) begin errs++; $display("FAIL br_fetch[%0d]: got %h want %h", i, sig(), SIG_FETCH); end
    end
  endtask
  task automatic test_jal();
    bus.opcode = OP_JAL;
    bus.immValue = 25'h0010000;
    nxt();
    checks++;
    if (bus.ImmSrc !== 2'b11) begin errs++; $display("FAIL jal_immsrc: got %b want 11", bus.ImmSrc); end
    checks++;
    if (bus.immExt !== 32'd8) begin errs++; $display("FAIL jal_immext: got %h want %h", bus.immExt, 32'd8); end
    nxt();
    checks++;
    if (sig() !== SIG_JAL) begin errs++; $display("FAIL jal_state: got %h want %h", sig(), SIG_JAL); end
    nxt();
    checks++;
    if (sig() !== SIG_ALUWB) begin errs++; $display("FAIL jal_aluwb: got %h want %h", sig(), SIG_ALUWB); end
    nxt();
    checks++;
    if (sig() !== SIG_FETCH) begin errs++; $display("FAIL jal_fetch: got %h want %h", sig(), SIG_FETCH); end
  endtask
  task automatic test_reset_mid();
    bus.opcode = OP_SW;
    nxt();
    nxt();
    checks++;
    if (sig() !== SIG_MEMADR) begin errs++; $display("FAIL sw_memadr: got %h want %h", sig(), SIG_MEMADR); end
    nxt();
    checks++;
    if (sig() !== SIG_MEMWR) begin errs++; $display("FAIL sw_memwrite: got %h want %h", sig(), SIG_MEMWR); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0) begin errs++; $display("FAIL midrst_memwrite: got %b want 0", bus.MemWrite); end
    checks++;
    if (sig() !== SIG_RST) begin errs++; $display("FAIL midrst_state: got %h want %h", sig(), SIG_RST); end
    nxt();
    checks++;
    if (sig() !== SIG_RST) begin errs++; $display("FAIL midrst_hold: got %h want %h", sig(), SIG_RST); end
    reset = 1'b0;
    #1;
    checks++;
    if (sig() !== SIG_FETCH) begin errs++; $display("FAIL midrst_release: got %h want %h", sig(), SIG_FETCH); end
  endtask
  initial begin
    bus.opcode = 7'd0;
    bus.func3 = 3'd0;
    bus.func7 = 7'd0;
    bus.immValue = 25'd0;
    bus.srcA = 32'd0;
    bus.srcB = 32'd0;
    test_reset();
    test_extend();
    test_release();
    test_lw();
    test_alu_ops();
    test_execi();
    test_branch();
    test_jal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_ext_unit.md
ALU_CTRL_EXT_UNIT -- requirements
Module: alu_ctrl_ext_unit

Interface
REQ-001 Parameters: none; all widths are fixed for RV32I.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  7; func3  in  3; func7  in  7  fields of the latched instruction.
REQ-005 immValue  in  25  instr[31:7].
REQ-006 srcA, srcB  in  32 each  ALU operands, selected outside this block.
REQ-007 IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite  out  1 each  datapath enables/select.
REQ-008 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  mux selects.
REQ-009 ALUControl  out  10  {func7,func3}-style operation code driven into the ALU.
REQ-010 ALUResult  out  32; Zero  out  1; immExt  out  32.

Function
REQ-011 Mux encodings SHALL be: ALUSrcA PC=00, OldPC=01, RD1=10; ALUSrcB RD2=00, ImmExt=01, const4=10; ResultSrc ALUOut=00, ReadData=01, ALUResult=10; AdrSrc PC=0, ALU/Result=1; code 11 is never driven.
REQ-012 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, with Moore outputs.
REQ-013 Transitions: FETCH->DECODE; DECODE: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, other->FETCH.
REQ-014 MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH; JAL->ALUWB.
REQ-015 FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, add, ResultSrc=10, PCWrite=1.
REQ-016 DECODE: SrcA=01, SrcB=01, add. MEMADR: SrcA=10, SrcB=01, add.
REQ-017 MEMREAD: ResultSrc=00, AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-018 EXECR: SrcA=10, SrcB=00, ALUControl={func7,func3}. EXECI: SrcA=10, SrcB=01, ALUControl={func7 if func3==101 else 0, func3}.
REQ-019 ALUWB: ResultSrc=00, RegWrite=1. JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1.
REQ-020 BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00, PCWrite=Zero for func3=000.
REQ-021 Unlisted outputs SHALL be 0; add=0000000_000 and sub=0100000_000.
REQ-022 ImmSrc SHALL be decoded from opcode as I=00 (lw, I-ALU), S=01, B=10, J=11, and 00 otherwise.
REQ-023 ALU ops by ALUControl: add, sub, sll(001), slt(010), sltu(011), xor(100), srl(0000000_101), sra(0100000_101), or(110), and(111).
REQ-024 Shift amount = srcB[4:0]; slt is signed; unrecognised codes yield 0.
REQ-025 The ALU SHALL be combinational with wrap-around arithmetic, and Zero=(ALUResult==0).
REQ-026 Extend: I={{20{iv[24]}},iv[24:13]}; S={{20{iv[24]}},iv[24:18],iv[4:0]}; B={{20{iv[24]}},iv[0],iv[23:18],iv[4:1],0}; J={{12{iv[24]}},iv[12:5],iv[13],iv[23:14],0}; combinational.

Reset
REQ-027 While reset=1: state SHALL be FETCH, and IRWrite, MemWrite, PCWrite, RegWrite SHALL be 0; other outputs follow FETCH.
REQ-028 Reset asserted mid-instruction SHALL abort it immediately, with no further write enables.

Configuration
REQ-029 With BRANCH_EXT_EN defined, BRANCH SHALL also support bne (func3=001, PCWrite=~Zero).
REQ-030 Without BRANCH_EXT_EN, branches with func3!=000 SHALL return to FETCH with PCWrite=0.

Structure
REQ-031 A shared package SHALL hold the state enum, opcode constants, mux encodings and ALUControl codes.
REQ-032 The ALU SHALL be one sub-module named alu_core; the FSM and extender stay in the top module.

Verification
REQ-033 Reset, then release: first cycle FETCH; IRWrite=PCWrite=1; with srcA=0, srcB=4 -> ALUResult=4.
REQ-034 lw opcode: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB over 5 cycles; RegWrite=1 with ResultSrc=01 only in cycle 5.
REQ-035 R-type sub, srcA=5, srcB=7 -> ALUResult=0xFFFFFFFE, Zero=0; sra with srcA=0x80000000, srcB=4 -> 0xF8000000; srl -> 0x08000000.
REQ-036 beq in BRANCH: srcA=srcB=9 -> PCWrite=1; srcA=9, srcB=8 -> PCWrite=0; 3 cycles total.
REQ-037 Extend: jal instr 0x0080006F (immValue=0x10000, ImmSrc=11) -> immExt=8; I-type instr[31:20]=0xFFF -> immExt=0xFFFFFFFF.
REQ-038 Reset asserted during MEMWRITE: MemWrite drops to 0 asynchronously and state=FETCH.
